// File: rtl/csr_uart_fifo.sv
// CSR-mapped UART: 8N1 transmitter holding one character, and a receiver feeding
// a FIFO so that back-to-back bytes survive between software polls.
module csr_uart_fifo #(
  parameter logic [11:0] BASE_ADDR  = 12'hBC0,
  parameter int          CLOCK_RATE = 200_000_000,
  parameter int          BAUD_RATE  = 115200,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        read,
  input  logic [2:0]  modify,
  input  logic [31:0] wdata,
  input  logic [11:0] addr,
  output logic [31:0] rdata,
  output logic        valid,
  input  logic        rx,
  output logic        tx,
  input  logic        AVOID_WARNING
);

  localparam int DIV = CLOCK_RATE / BAUD_RATE;
  localparam int CW  = $clog2(DIV) + 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BIT_CNT  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_CNT = CW'(DIV / 2 - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  uart_state_t rx_state, tx_state;
  logic          rx_meta, rx_sync;
  logic [CW-1:0] rx_cnt, tx_cnt;
  logic [2:0]    rx_bits, tx_bits;
  logic [7:0]    rx_shift, tx_shift;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          overflow;
  logic          write, write_tx, clear_ovf;
  logic          empty, full, pop, rx_push, push_ok;
  logic [7:0]    head;
  logic          unused_bits;

  assign valid     = (addr == BASE_ADDR);
  assign write     = valid && (modify != 3'd0);
  assign clear_ovf = write && wdata[9];
  assign write_tx  = write && !wdata[9] && (tx_state == IDLE);

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head    = mem[rd_ptr[AW-1:0]];
  assign pop     = valid && read && !empty;
  assign rx_push = (rx_state == STOP) && (rx_cnt == '0) && rx_sync;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept the push.
  assign push_ok = rx_push && (!full || pop);

  assign unused_bits = ^{AVOID_WARNING, wdata[31:10], wdata[8]};

  always_comb begin
    rdata = '0;
    if (valid) rdata = {21'b0, overflow, (tx_state != IDLE), empty, (empty ? 8'h00 : head)};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (rx_push && !push_ok) overflow <= 1'b1;
      else if (clear_ovf)      overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= rx_shift;
  end

  // Receiver: start edge is re-checked at mid-bit, then each bit sampled one period later.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_state <= IDLE;
      rx_cnt   <= '0;
      rx_bits  <= '0;
      rx_shift <= '0;
    end else begin
      case (rx_state)
        IDLE: if (!rx_sync) begin
          rx_state <= START;
          rx_cnt   <= HALF_CNT;
        end
        START: if (rx_cnt != '0) rx_cnt <= rx_cnt - 1'b1;
          else if (!rx_sync) begin
            rx_state <= DATA;
            rx_cnt   <= BIT_CNT;
            rx_bits  <= '0;
          end else rx_state <= IDLE;
        DATA: if (rx_cnt != '0) rx_cnt <= rx_cnt - 1'b1;
          else begin
            rx_shift <= {rx_sync, rx_shift[7:1]};
            rx_cnt   <= BIT_CNT;
            rx_bits  <= rx_bits + 1'b1;
            if (rx_bits == 3'd7) rx_state <= STOP;
          end
        STOP: if (rx_cnt != '0) rx_cnt <= rx_cnt - 1'b1;
          else rx_state <= IDLE;
        default: rx_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_bits  <= '0;
      tx_shift <= '0;
      tx       <= 1'b1;
    end else begin
      case (tx_state)
        IDLE: if (write_tx) begin
          tx_state <= START;
          tx_cnt   <= BIT_CNT;
          tx_shift <= wdata[7:0];
          tx       <= 1'b0;
        end
        START: if (tx_cnt != '0) tx_cnt <= tx_cnt - 1'b1;
          else begin
            tx_state <= DATA;
            tx_cnt   <= BIT_CNT;
            tx_bits  <= '0;
            tx       <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
          end
        DATA: if (tx_cnt != '0) tx_cnt <= tx_cnt - 1'b1;
          else begin
            tx_cnt <= BIT_CNT;
            if (tx_bits == 3'd7) begin
              tx_state <= STOP;
              tx       <= 1'b1;
            end else begin
              tx_bits  <= tx_bits + 1'b1;
              tx       <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[7:1]};
            end
          end
        STOP: if (tx_cnt != '0) tx_cnt <= tx_cnt - 1'b1;
          else tx_state <= IDLE;
        default: tx_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_uart_fifo.sv
// Testbench for csr_uart_fifo: RX bytes go through a scoreboard queue, TX frames
// are checked bit by bit, plus glitch, framing-error, overflow and reset cases.
module tb_csr_uart_fifo;

  localparam int DIV = 10;
  localparam logic [11:0] BASE = 12'hBC0;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        read = 1'b0;
  logic [2:0]  modify = 3'd0;
  logic [31:0] wdata = 32'd0;
  logic [11:0] addr = 12'd0;
  logic [31:0] rdata;
  logic        valid;
  logic        rx = 1'b1;
  logic        tx;
  logic        avoid_warning = 1'b0;

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];
  logic       exp_ovf = 1'b0;

  csr_uart_fifo #(
    .BASE_ADDR(12'hBC0), .CLOCK_RATE(1_000_000), .BAUD_RATE(100_000), .FIFO_DEPTH(16)
  ) dut (
    .clk(clk), .rstn(rstn), .read(read), .modify(modify), .wdata(wdata), .addr(addr),
    .rdata(rdata), .valid(valid), .rx(rx), .tx(tx), .AVOID_WARNING(avoid_warning)
  );

  always #5 clk = ~clk;

  task automatic csr_access(input logic rd, input logic [2:0] md, input logic [31:0] wd,
                            input logic [11:0] a, output logic [31:0] data, output logic vld);
    @(negedge clk);
    read = rd; modify = md; wdata = wd; addr = a;
    #1;
    data = rdata;
    vld = valid;
    @(posedge clk);
    #1;
    read = 1'b0; modify = 3'd0; wdata = 32'd0; addr = 12'd0;
  endtask

  // Drives one 8N1 frame on rx and records what the receiver should end up holding.
  task automatic rx_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rx = bits[i];
      repeat (DIV - 1) @(negedge clk);
    end
    @(negedge clk);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    if (stop_bit) begin
      if (exp_q.size() < 16) exp_q.push_back(b);
      else exp_ovf = 1'b1;
    end
  endtask

  function automatic logic [31:0] model_read();
    logic [31:0] w;
    w = 32'd0;
    w[10] = exp_ovf;
    if (exp_q.size() == 0) w[8] = 1'b1;
    else w[7:0] = exp_q.pop_front();
    return w;
  endfunction

  task automatic test_reset();
    logic [31:0] d;
    logic v;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (tx !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_tx_in_reset got=%b want=1", tx); end
    @(negedge clk);
    rstn = 1'b1;
    csr_access(1'b1, 3'd0, 32'd0, BASE, d, v);
    n_checks++;
    if (d !== 32'h100) begin n_fail++; $display("[TB] FAIL reset_rdata got=%h want=%h", d, 32'h100); end
    n_checks++;
    if (v !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_valid got=%b want=1", v); end
    n_checks++;
    if (tx !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_tx got=%b want=1", tx); end
    csr_access(1'b1, 3'd0, 32'd0, 12'hBC1, d, v);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("[TB] FAIL other_addr_rdata got=%h want=0", d); end
    n_checks++;
    if (v !== 1'b0) begin n_fail++; $display("[TB] FAIL other_addr_valid got=%b want=0", v); end
  endtask

  task automatic test_rx_basic();
    logic [31:0] d, e;
    logic v;
    rx_frame(8'h55, 1'b1);
    rx_frame(8'hA3, 1'b1);
    for (int i = 0; i < 3; i++) begin
      e = model_read();
      csr_access(1'b1, 3'd0, 32'd0, BASE, d, v);
      n_checks++;
      if (d !== e) begin n_fail++; $display("[TB] FAIL rx_basic_read%0d got=%h want=%h", i, d, e); end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] d, e;
    logic v;
    for (int i = 0; i < 17; i++) rx_frame(8'(i), 1'b1);
    for (int i = 0; i < 17; i++) begin
      e = model_read();
      csr_access(1'b1, 3'd0, 32'd0, BASE, d, v);
      n_checks++;
      if (d !== e) begin n_fail++; $display("[TB] FAIL overflow_read%0d got=%h want=%h", i, d, e); end
    end
    csr_access(1'b0, 3'd1, 32'h200, BASE, d, v);
    exp_ovf = 1'b0;
    e = model_read();
    csr_access(1'b1, 3'd0, 32'd0, BASE, d, v);
    n_checks++;
    if (d !== e) begin n_fail++; $display("[TB] FAIL overflow_clear got=%h want=%h", d, e); end
  endtask

  task automatic test_rx_errors();
    logic [31:0] d, e;
    logic v;
    @(negedge clk);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    e = model_read();
    csr_access(1'b1, 3'd0, 32'd0, BASE, d, v);
    n_checks++;
    if (d !== e) begin n_fail++; $display("[TB] FAIL glitch_reject got=%h want=%h", d, e); end
    rx_frame(8'h7E, 1'b0);
    repeat (20) @(negedge clk);
    e = model_read();
    csr_access(1'b1, 3'd0, 32'd0, BASE, d, v);
    n_checks++;
    if (d !== e) begin n_fail++; $display("[TB] FAIL framing_error got=%h want=%h", d, e); end
  endtask

  task automatic test_tx_frame();
    logic [31:0] d;
    logic v, exp_tx;
    logic [7:0] ch;
    int low_seen;
    ch = 8'h4B;
    csr_access(1'b0, 3'd1, {24'd0, ch}, BASE, d, v);
    for (int c = 0; c < 100; c++) begin
      addr = BASE;
      read = 1'b0;
      modify = (c == 30) ? 3'd1 : 3'd0;
      wdata = (c == 30) ? 32'h11 : 32'd0;
      if (c < 10) exp_tx = 1'b0;
      else if (c < 90) exp_tx = ch[(c - 10) / 10];
      else exp_tx = 1'b1;
      #1;
      n_checks++;
      if (tx !== exp_tx) begin n_fail++; $display("[TB] FAIL tx_bit cycle=%0d got=%b want=%b", c, tx, exp_tx); end
      n_checks++;
      if (rdata[9] !== 1'b1) begin n_fail++; $display("[TB] FAIL tx_busy cycle=%0d got=%b want=1", c, rdata[9]); end
      @(posedge clk);
      #1;
    end
    modify = 3'd0;
    wdata = 32'd0;
    #1;
    n_checks++;
    if (rdata[9] !== 1'b0) begin n_fail++; $display("[TB] FAIL tx_busy_after got=%b want=0", rdata[9]); end
    low_seen = 0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (tx !== 1'b1) low_seen++;
    end
    n_checks++;
    if (low_seen != 0) begin n_fail++; $display("[TB] FAIL dropped_write low_cycles got=%0d want=0", low_seen); end
    addr = 12'd0;
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] d, e;
    logic v;
    rx_frame(8'h3C, 1'b1);
    csr_access(1'b0, 3'd1, 32'h4B, BASE, d, v);
    repeat (35) @(posedge clk);
    #2;
    n_checks++;
    if (tx !== 1'b0) begin n_fail++; $display("[TB] FAIL pre_reset_tx got=%b want=0", tx); end
    rstn = 1'b0;
    #1;
    n_checks++;
    if (tx !== 1'b1) begin n_fail++; $display("[TB] FAIL async_reset_tx got=%b want=1", tx); end
    addr = BASE;
    #1;
    n_checks++;
    if (rdata !== 32'h100) begin n_fail++; $display("[TB] FAIL in_reset_rdata got=%h want=%h", rdata, 32'h100); end
    addr = 12'd0;
    exp_q.delete();
    exp_ovf = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    e = model_read();
    csr_access(1'b1, 3'd0, 32'd0, BASE, d, v);
    n_checks++;
    if (d !== e) begin n_fail++; $display("[TB] FAIL post_reset_rdata got=%h want=%h", d, e); end
    n_checks++;
    if (tx !== 1'b1) begin n_fail++; $display("[TB] FAIL post_reset_tx got=%b want=1", tx); end
  endtask

  initial begin
    test_reset();
    test_rx_basic();
    test_overflow();
    test_rx_errors();
    test_tx_frame();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
